multicycle_ctrl: RTL

Main control FSM for the multi-cycle MIPS datapath. It sequences instruction fetch, decode, execute, memory access and writeback over several cycles, and stalls on a memory ready handshake. It drives the datapath mux selects and write enables, and produces the 2-bit aluop that feeds the ALU control decoder. It also keeps a retired-instruction counter for debug and performance checks.

---
 rtl/multicycle_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, stalls on mem_ready,
// drives datapath selects and write enables, and counts retired instructions.
// Optional build macro: MULTICYCLE_CTRL_BNE_EN (adds BNE, opcode 6'b000101).
module multicycle_ctrl #(
  parameter int          CNT_W    = 32,
  parameter logic [5:0]  OP_RTYPE = 6'b000000,
  parameter logic [5:0]  OP_LW    = 6'b100011,
  parameter logic [5:0]  OP_SW    = 6'b101011,
  parameter logic [5:0]  OP_BEQ   = 6'b000100,
  parameter logic [5:0]  OP_J     = 6'b000010,
  parameter logic [5:0]  OP_ADDI  = 6'b001000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE = 6'b000101;
`endif

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   retire;

  assign state = cur_state;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= FETCH;
    else     cur_state <= nxt_state;
  end

  // Retired-instruction counter, bumped on the last cycle of each instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  // Next-state and control decode; everything held at 0 while in reset
  always_comb begin
    nxt_state  = cur_state;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_source  = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    aluop      = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    if (!rst) begin
      case (cur_state)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
          if (mem_ready) nxt_state = DECODE;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          if (opcode == OP_LW || opcode == OP_SW) nxt_state = MEMADR;
          else if (opcode == OP_RTYPE)            nxt_state = EXEC;
          else if (opcode == OP_BEQ)              nxt_state = BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
          else if (opcode == OP_BNE)              nxt_state = BRANCH;
`endif
          else if (opcode == OP_J)                nxt_state = JUMP;
          else if (opcode == OP_ADDI)             nxt_state = ADDIEX;
          else begin
            nxt_state  = FETCH;
            illegal_op = 1'b1;
          end
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          nxt_state = (opcode == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) nxt_state = MEMWB;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
          nxt_state  = FETCH;
        end
        MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            retire    = 1'b1;
            nxt_state = FETCH;
          end
        end
        EXEC: begin
          alu_src_a = 1'b1;
          aluop     = 2'b10;
          nxt_state = RWB;
        end
        RWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
          nxt_state = FETCH;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          aluop     = 2'b11;
          pc_source = 2'b01;
`ifdef MULTICYCLE_CTRL_BNE_EN
          // IR still holds the branch opcode, so it selects the taken sense
          pc_en     = (opcode == OP_BNE) ? ~zero : zero;
`else
          pc_en     = zero;
`endif
          retire    = 1'b1;
          nxt_state = FETCH;
        end
        JUMP: begin
          pc_source = 2'b10;
          pc_en     = 1'b1;
          retire    = 1'b1;
          nxt_state = FETCH;
        end
        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          nxt_state = ADDIWB;
        end
        ADDIWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          nxt_state = FETCH;
        end
        default: nxt_state = FETCH;
      endcase
    end
  end

endmodule
